// File: rtl/dii_package.sv
// Shared debug-interconnect flit type used on the debug ring links.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/dii_pkt_fifo.sv
// Debug-ring flit buffer: plain FIFO or store-and-forward packet buffer with
// a cut-through escape for packets larger than the buffer.
module dii_pkt_fifo
    import dii_package::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FULLPACKET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  dii_flit                  flit_in,
    output logic                     flit_in_ready,
    output dii_flit                  flit_out,
    input  logic                     flit_out_ready,
    output logic [$clog2(DEPTH):0]   packet_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            cutthrough;

    logic            full;
    logic            empty;
    logic [WIDTH:0]  head;
    logic            wr_en;
    logic            rd_en;
    logic            wr_last;
    logic            rd_last;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Handshake outputs depend only on registered state and reset.
    always_comb begin
        flit_in_ready  = !full && !rst;
        flit_out       = '0;
        flit_out.last  = head[WIDTH];
        flit_out.data  = head[WIDTH-1:0];
        if (FULLPACKET == 0) begin
            flit_out.valid = !empty && !rst;
        end else begin
            flit_out.valid = !empty && !rst && ((packet_count != '0) || cutthrough);
        end
    end

    assign wr_en   = flit_in.valid && flit_in_ready;
    assign rd_en   = flit_out.valid && flit_out_ready;
    assign wr_last = wr_en && flit_in.last;
    assign rd_last = rd_en && head[WIDTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {flit_in.last, flit_in.data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            packet_count <= '0;
            cutthrough   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case ({wr_last, rd_last})
                2'b10:   packet_count <= packet_count + CW'(1);
                2'b01:   packet_count <= packet_count - CW'(1);
                default: packet_count <= packet_count;
            endcase

            // A full buffer with no complete packet can only drain by cutting through.
            if (FULLPACKET == 0) begin
                cutthrough <= 1'b0;
            end else if (rd_last) begin
                cutthrough <= 1'b0;
            end else if (full && (packet_count == '0)) begin
                cutthrough <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dii_pkt_fifo.md
DII_PKT_FIFO -- requirements
Module: dii_pkt_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning flit data width; it matches dii_flit data.
REQ-002 SHALL have parameter DEPTH, default 16, meaning buffer depth in flits; it is a power of two and at least 2.
REQ-003 SHALL have parameter FULLPACKET, default 1, meaning 1 = store-and-forward, 0 = plain flit FIFO.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flit_in, input, dii_flit: upstream flit {valid, last, data}; it connects to a debug ring output.
REQ-007 SHALL have port flit_in_ready, output, 1 bit: the buffer accepts flit_in this cycle.
REQ-008 SHALL have port flit_out, output, dii_flit: downstream flit; it feeds a debug ring input.
REQ-009 SHALL have port flit_out_ready, input, 1 bit: downstream accepts flit_out this cycle.
REQ-010 SHALL have port packet_count, output, $clog2(DEPTH)+1 bits: number of complete packets held.

Function
REQ-011 SHALL store flits in a DEPTH-entry array of {last, data}, with write/read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a flit count of $clog2(DEPTH)+1 bits.
REQ-012 SHALL accept a flit (write) when flit_in.valid && flit_in_ready; it SHALL drive flit_in_ready = (count != DEPTH) && !rst, from registered state only.
REQ-013 SHALL retire a flit (read) when flit_out.valid && flit_out_ready; flit_out.data/last SHALL be the entry at the read pointer.
REQ-014 SHALL increment packet_count on a write with last=1 and decrement it on a read with last=1; if both happen in the same cycle, packet_count SHALL be unchanged.
REQ-015 SHALL update count as: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-016 When FULLPACKET=0, SHALL drive flit_out.valid = (count != 0).
REQ-017 When FULLPACKET=1, SHALL drive flit_out.valid = (count != 0) && (packet_count != 0 || cutthrough).
REQ-018 cutthrough register (FULLPACKET=1): SHALL set when count == DEPTH and packet_count == 0 (oversized packet); SHALL clear on the read of a last=1 flit. This prevents deadlock.
REQ-019 Minimum latency SHALL be 1 cycle: a flit written at edge N is visible on flit_out after edge N. Store-and-forward: the first flit becomes valid the cycle after its packet's last flit is written.
REQ-020 Full: a write while count == DEPTH SHALL be impossible, because ready is low; a simultaneous read does not raise ready in the same cycle.
REQ-021 Empty: flit_out.valid SHALL be 0 and flit_out.data is don't-care.
REQ-022 flit_out.valid, once asserted, SHALL stay asserted with stable data until accepted.
REQ-023 SHALL have no combinational path from flit_in to flit_out or from flit_out_ready to flit_in_ready.

Reset
REQ-024 On rst=1 at a clock edge, SHALL clear pointers, count, packet_count and cutthrough to 0. Array contents are not reset.
REQ-025 While rst=1, SHALL drive flit_in_ready=0 and flit_out.valid=0. In the cycle after rst deasserts, flit_in_ready=1 and packet_count=0.
REQ-026 Reset mid-packet SHALL discard all buffered flits, including partial packets; no flit emerges afterwards.

Structure
REQ-027 SHALL use dii_flit from dii_package unchanged; no new package types or constants are required.
REQ-028 SHALL be a single module with no sub-module; the storage is an inferred register/LUT array.

Verification
REQ-029 Scenario: FULLPACKET=1, write a 3-flit packet (0x1111, 0x2222, 0x3333 last), flit_out_ready=1 -> flit_out.valid=0 until the cycle after 0x3333 is written, then 3 consecutive flits in order, last only on 0x3333, packet_count 1->0.
REQ-030 Scenario: FULLPACKET=0, DEPTH=4, flit_out_ready=0, write 5 flits -> flit_in_ready drops after the 4th; release ready -> 4 flits out, then the 5th accepted.
REQ-031 Scenario: FULLPACKET=1, DEPTH=4, 6-flit packet -> cutthrough after 4 flits, all 6 delivered in order, cutthrough cleared after last, packet_count ends 0.
REQ-032 Scenario: simultaneous write of a last flit and read of a last flit with packet_count=1 -> packet_count stays 1; count unchanged.
REQ-033 Scenario: assert rst with 2 flits of a partial packet buffered -> next cycle count=0, valid=0; a new 1-flit packet 0xABCD (last) emerges alone.
REQ-034 Scenario: random valid/ready throttling over 1000 packets of length 1..DEPTH -> output stream equals input stream, no valid drop without handshake.
